// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM among NUM_REQ requesters,
// with optional bounded grant locking and a one-cycle read response strobe.
module bram_port_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int LOCK_MAX   = 16
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [NUM_REQ-1:0]               req_valid,
   input  logic [NUM_REQ-1:0]               req_write,
   input  logic [NUM_REQ-1:0]               req_lock,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_address,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_writeData,
   output logic [NUM_REQ-1:0]               req_ready,
   output logic [NUM_REQ-1:0]               resp_valid,
   output logic [DATA_WIDTH-1:0]            resp_data,
   output logic                             bram_readEnable,
   output logic                             bram_writeEnable,
   output logic [ADDR_WIDTH-1:0]            bram_address,
   output logic [DATA_WIDTH-1:0]            bram_writeData,
   input  logic [DATA_WIDTH-1:0]            bram_readData
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(LOCK_MAX + 1);
   localparam logic [IDX_W-1:0] LAST_RST   = IDX_W'(NUM_REQ - 1);
   localparam logic [CNT_W-1:0] LOCK_MAX_C = CNT_W'(LOCK_MAX);
   localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);
   localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);
   // A limit of one consecutive grant means locking can never take effect.
   localparam bit LOCK_EN = (LOCK_MAX > 1);

   typedef enum logic [0:0] {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } lock_state_t;

   lock_state_t        state_r, state_nxt_s;
   logic [IDX_W-1:0]   last_grant_r;
   logic [IDX_W-1:0]   lock_owner_r, lock_owner_nxt_s;
   logic [CNT_W-1:0]   lock_count_r, lock_count_nxt_s;
   logic [NUM_REQ-1:0] resp_valid_r, resp_nxt_s;
   logic               grant_found_s;
   logic [IDX_W-1:0]   grant_idx_s;

   function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base, input int offset);
      return IDX_W'((int'(base) + offset) % NUM_REQ);
   endfunction

   // Grant selection: lock owner only while locked, else round-robin after last_grant.
   always_comb begin
      grant_found_s = 1'b0;
      grant_idx_s   = '0;
      if (state_r == LOCKED) begin
         grant_found_s = req_valid[lock_owner_r];
         grant_idx_s   = lock_owner_r;
      end else begin
         for (int i = NUM_REQ; i >= 1; i--) begin
            if (req_valid[rr_index(last_grant_r, i)]) begin
               grant_found_s = 1'b1;
               grant_idx_s   = rr_index(last_grant_r, i);
            end else begin
               grant_idx_s   = grant_idx_s;
            end
         end
      end
   end

   assign req_ready        = grant_found_s ? (ONE_HOT0 << grant_idx_s) : '0;
   assign bram_readEnable  = grant_found_s & ~req_write[grant_idx_s];
   assign bram_writeEnable = grant_found_s &  req_write[grant_idx_s];
   assign bram_address     = grant_found_s ? req_address[int'(grant_idx_s)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
   assign bram_writeData   = grant_found_s ? req_writeData[int'(grant_idx_s)*DATA_WIDTH +: DATA_WIDTH] : '0;
   assign resp_data        = bram_readData;
   assign resp_valid       = resp_valid_r;

   // Lock FSM next state and read response strobe.
   always_comb begin
      state_nxt_s      = state_r;
      lock_owner_nxt_s = lock_owner_r;
      lock_count_nxt_s = lock_count_r;
      resp_nxt_s       = (grant_found_s && !req_write[grant_idx_s]) ? req_ready : '0;
      case (state_r)
         UNLOCKED: begin
            if (grant_found_s && req_lock[grant_idx_s] && LOCK_EN) begin
               state_nxt_s      = LOCKED;
               lock_owner_nxt_s = grant_idx_s;
               lock_count_nxt_s = ONE_C;
            end else begin
               state_nxt_s      = UNLOCKED;
            end
         end
         LOCKED: begin
            if (grant_found_s && req_lock[lock_owner_r]) begin
               // The grant that reaches the limit still completes, then the lock ends.
               if ((lock_count_r + ONE_C) == LOCK_MAX_C) begin
                  state_nxt_s      = UNLOCKED;
                  lock_count_nxt_s = '0;
               end else begin
                  lock_count_nxt_s = lock_count_r + ONE_C;
               end
            end else begin
               state_nxt_s      = UNLOCKED;
               lock_count_nxt_s = '0;
            end
         end
         default: begin
            state_nxt_s      = UNLOCKED;
            lock_owner_nxt_s = '0;
            lock_count_nxt_s = '0;
         end
      endcase
   end

   // State registers; last_grant only moves on a granted cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r      <= UNLOCKED;
         last_grant_r <= LAST_RST;
         lock_owner_r <= '0;
         lock_count_r <= '0;
         resp_valid_r <= '0;
      end else begin
         state_r      <= state_nxt_s;
         lock_owner_r <= lock_owner_nxt_s;
         lock_count_r <= lock_count_nxt_s;
         resp_valid_r <= resp_nxt_s;
         if (grant_found_s) begin
            last_grant_r <= grant_idx_s;
         end else begin
            last_grant_r <= last_grant_r;
         end
      end
   end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter: vector table plus lock/reset
// sequences, with a scoreboard queue of expected read responses.
module tb_bram_port_arbiter;

   logic         clock = 1'b0;
   logic         reset;
   logic [3:0]   req_valid, req_write, req_lock;
   logic [31:0]  req_address;
   logic [127:0] req_writeData;
   logic [3:0]   req_ready, resp_valid;
   logic [31:0]  resp_data;
   logic         bram_readEnable, bram_writeEnable;
   logic [7:0]   bram_address;
   logic [31:0]  bram_writeData;
   logic [31:0]  bram_readData;

   bram_port_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .ADDR_WIDTH(8), .LOCK_MAX(16)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_write(req_write), .req_lock(req_lock),
      .req_address(req_address), .req_writeData(req_writeData),
      .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
      .bram_readEnable(bram_readEnable), .bram_writeEnable(bram_writeEnable),
      .bram_address(bram_address), .bram_writeData(bram_writeData),
      .bram_readData(bram_readData)
   );

   always #5 clock = ~clock;

   // BRAM model with one-cycle read latency.
   logic [31:0] bram_mem [256];
   always @(posedge clock) begin
      if (bram_writeEnable) bram_mem[bram_address] <= bram_writeData;
      if (bram_readEnable)  bram_readData <= bram_mem[bram_address];
   end

   typedef struct { logic [3:0] v; logic [3:0] w; logic [3:0] l; logic [3:0] exp; } vec_t;
   typedef struct { logic [3:0] rv; logic [31:0] data; } sb_t;

   vec_t        vecs [13];
   sb_t         sb_q [$];
   logic [7:0]  addr_tab [4];
   logic [31:0] data_tab [4];
   logic [31:0] ref_mem [256];
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int oh_idx(input logic [3:0] oh);
      for (int i = 0; i < 4; i++) if (oh[i]) return i;
      return 0;
   endfunction

   task automatic drive_check(input logic [3:0] v, input logic [3:0] w, input logic [3:0] l,
                              input logic [3:0] exp, input string name);
      sb_t item;
      int  k;
      req_valid = v;
      req_write = w;
      req_lock  = l;
      @(negedge clock);
      k = oh_idx(exp);
      check({name, ".ready"}, {28'd0, req_ready}, {28'd0, exp});
      check({name, ".rd_en"}, {31'd0, bram_readEnable},  {31'd0, |(exp & ~w)});
      check({name, ".wr_en"}, {31'd0, bram_writeEnable}, {31'd0, |(exp & w)});
      check({name, ".addr"},  {24'd0, bram_address}, (exp != 4'd0) ? {24'd0, addr_tab[k]} : 32'd0);
      check({name, ".wdata"}, bram_writeData, (exp != 4'd0) ? data_tab[k] : 32'd0);
      if (sb_q.size() == 0) begin
         check({name, ".sb_empty"}, 32'd1, 32'd0);
      end else begin
         item = sb_q.pop_front();
         check({name, ".resp_valid"}, {28'd0, resp_valid}, {28'd0, item.rv});
         if (item.rv != 4'd0) check({name, ".resp_data"}, resp_data, item.data);
      end
      item.rv   = exp & ~w;
      item.data = 32'd0;
      if ((exp & w) != 4'd0) ref_mem[addr_tab[k]] = data_tab[k];
      if (item.rv != 4'd0) item.data = ref_mem[addr_tab[k]];
      sb_q.push_back(item);
      @(posedge clock);
      #1;
   endtask

   initial begin
      sb_t zero_item;
      zero_item.rv = 4'd0;
      zero_item.data = 32'd0;
      for (int i = 0; i < 256; i++) begin
         bram_mem[i] = 32'd0;
         ref_mem[i]  = 32'd0;
      end
      bram_readData = 32'd0;
      addr_tab[0] = 8'h20; addr_tab[1] = 8'h10; addr_tab[2] = 8'h10; addr_tab[3] = 8'h30;
      data_tab[0] = 32'h1111_1111; data_tab[1] = 32'hDEAD_BEEF;
      data_tab[2] = 32'h2222_2222; data_tab[3] = 32'h3333_3333;
      for (int i = 0; i < 4; i++) begin
         req_address[i*8 +: 8]     = addr_tab[i];
         req_writeData[i*32 +: 32] = data_tab[i];
      end
      vecs[0]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0001};
      vecs[1]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0010};
      vecs[2]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0100};
      vecs[3]  = '{4'b1111, 4'b0000, 4'b0000, 4'b1000};
      vecs[4]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0001};
      vecs[5]  = '{4'b0010, 4'b0010, 4'b0000, 4'b0010};
      vecs[6]  = '{4'b0100, 4'b0000, 4'b0000, 4'b0100};
      vecs[7]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
      vecs[8]  = '{4'b1001, 4'b1001, 4'b0000, 4'b1000};
      vecs[9]  = '{4'b1001, 4'b0001, 4'b0000, 4'b0001};
      vecs[10] = '{4'b1001, 4'b0000, 4'b0000, 4'b1000};
      vecs[11] = '{4'b0001, 4'b0000, 4'b0000, 4'b0001};
      vecs[12] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};

      reset = 1'b0;
      req_valid = 4'd0; req_write = 4'd0; req_lock = 4'd0;
      #12;
      check("reset.resp_valid", {28'd0, resp_valid}, 32'd0);
      check("reset.rd_en", {31'd0, bram_readEnable}, 32'd0);
      check("reset.wr_en", {31'd0, bram_writeEnable}, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      sb_q.push_back(zero_item);

      for (int i = 0; i < 13; i++)
         drive_check(vecs[i].v, vecs[i].w, vecs[i].l, vecs[i].exp, $sformatf("vec%0d", i));

      // Requester 3 holds a lock: 16 consecutive grants, then round-robin resumes at 0.
      drive_check(4'b1000, 4'b0000, 4'b1000, 4'b1000, "lock_first");
      for (int i = 0; i < 15; i++)
         drive_check(4'b1111, 4'b0000, 4'b1000, 4'b1000, $sformatf("lock_hold%0d", i));
      drive_check(4'b1111, 4'b0000, 4'b1000, 4'b0001, "lock_max_release");
      drive_check(4'b0000, 4'b0000, 4'b0000, 4'b0000, "lock_idle");

      // Lock owner 2 drops its request for a cycle.
      drive_check(4'b0100, 4'b0000, 4'b0100, 4'b0100, "own2_lock");
      drive_check(4'b0101, 4'b0000, 4'b0100, 4'b0100, "own2_hold");
      drive_check(4'b0001, 4'b0000, 4'b0000, 4'b0000, "own2_drop");
      drive_check(4'b0001, 4'b0000, 4'b0000, 4'b0001, "after_drop");

      // Reset right after a locked, granted read.
      drive_check(4'b0010, 4'b0000, 4'b0010, 4'b0010, "pre_rst_rd");
      req_valid = 4'd0; req_lock = 4'd0;
      #1 reset = 1'b0;
      #1 check("rst_mid.resp_valid", {28'd0, resp_valid}, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      sb_q.delete();
      sb_q.push_back(zero_item);
      drive_check(4'b1111, 4'b0000, 4'b0000, 4'b0001, "post_rst");

      for (int i = 0; i < 10; i++)
         drive_check(4'b0000, 4'b0000, 4'b0000, 4'b0000, $sformatf("idle%0d", i));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
